dbf_ch_dynfocus: RTL and testbench

//  Parametrised per-channel beamforming element for the DBF array: coarse integer delay, linear-interp fine delay, apodisation, round/saturate.

---
 rtl/dbf_ch_dynfocus.sv | 276 +++++++++++++++++++++++++++
 tb/tb_dbf_ch_dynfocus.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbf_ch_dynfocus.sv
// Per-channel DBF element: coarse/fine delay, apodisation, round/saturate, dynamic focus.
// Optional macro DBF_FINE_INTERP_EN enables the linear-interpolation fine delay.
module dbf_ch_dynfocus #(
    parameter int INPUT_WD = 14,
    parameter int APO_WD   = 16,
    parameter int CD_WD    = 6,
    parameter int FRAC_WD  = 4,
    parameter int ADDR_WD  = 8,
    parameter int ZONE_LEN = 32,
    parameter int OUT_WD   = 32,
    parameter int SHIFT    = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     tx_en,
    input  logic [INPUT_WD-1:0]      ch_in,
    input  logic [APO_WD-1:0]        apo_din,
    input  logic                     lut_we,
    input  logic [ADDR_WD-1:0]       lut_waddr,
    input  logic [CD_WD+FRAC_WD-1:0] lut_wdata,
    output logic [OUT_WD-1:0]        dout,
    output logic                     dout_valid,
    output logic [INPUT_WD-1:0]      cd_dout,
    output logic                     busy
);
    localparam int DEPTH     = 2 ** CD_WD;
    localparam int LW        = CD_WD + FRAC_WD;
    localparam int CNT_WD    = CD_WD + 1;
    localparam int ZC_WD     = (ZONE_LEN > 1) ? $clog2(ZONE_LEN) : 1;
    localparam int YW        = INPUT_WD + 1;
    localparam int PW        = YW + APO_WD;
    localparam int RW        = PW + 1;
    localparam int SW        = ((RW > OUT_WD) ? RW : OUT_WD) + 1;
    localparam int FLUSH_LEN = 5;

    localparam logic [CD_WD-1:0] CMAX = CD_WD'(DEPTH - 2);
    localparam logic signed [RW-1:0] RND = RW'((2 ** SHIFT) >> 1);
    localparam logic signed [SW-1:0] OMAX =
        {{(SW-OUT_WD+1){1'b0}}, {(OUT_WD-1){1'b1}}};
    localparam logic signed [SW-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          flush_cnt_q, flush_cnt_d;
    logic [CD_WD-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_WD-1:0]   sample_cnt_q, sample_cnt_d;
    logic [ZC_WD-1:0]    zone_cnt_q, zone_cnt_d;
    logic [ADDR_WD-1:0]  zone_addr_q, zone_addr_d;
    logic                accept;
    logic                clr;

    logic [INPUT_WD-1:0] buf_mem [DEPTH];
    logic [LW-1:0]       lut_mem [2**ADDR_WD];
    logic [LW-1:0]       lut_rd;
    logic [CD_WD-1:0]    coarse_c;
    logic [CD_WD-1:0]    rd0;
    logic [INPUT_WD-1:0] x0;

    logic                s1_valid_q, s1_valid_d;
    logic [CD_WD-1:0]    s1_ptr_q, s1_ptr_d;
    logic [CNT_WD-1:0]   s1_cnt_q, s1_cnt_d;
    logic [CD_WD-1:0]    s1_coarse_q, s1_coarse_d;

    logic                       s2_valid_q, s2_valid_d;
    logic signed [INPUT_WD-1:0] s2_x0_q, s2_x0_d;

    logic                 s3_valid_q, s3_valid_d;
    logic signed [YW-1:0] s3_y_q, s3_y_d;

    logic                 s4_valid_q, s4_valid_d;
    logic signed [PW-1:0] s4_p_q, s4_p_d;

    logic [OUT_WD-1:0]    dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;

    logic signed [RW-1:0] rnd_c;
    logic signed [RW-1:0] shr_c;
    logic signed [SW-1:0] ext_c;
    logic signed [SW-1:0] sat_c;

`ifdef DBF_FINE_INTERP_EN
    localparam int FIW = YW + FRAC_WD + 1;
    logic [FRAC_WD-1:0]         s1_frac_q, s1_frac_d;
    logic [FRAC_WD-1:0]         s2_frac_q, s2_frac_d;
    logic signed [INPUT_WD-1:0] s2_x1_q, s2_x1_d;
    logic [CD_WD-1:0]           rd1;
    logic [INPUT_WD-1:0]        x1;
    logic signed [FIW-1:0]      x0_e, x1_e, fr_e, prod_f;
`else
    logic unused_frac;
    assign unused_frac = ^lut_rd[FRAC_WD-1:0];
`endif

    always_comb begin : fsm
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        sample_cnt_d = sample_cnt_q;
        zone_cnt_d   = zone_cnt_q;
        zone_addr_d  = zone_addr_q;
        accept       = 1'b0;
        clr          = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    clr     = 1'b1;
                end
            end
            S_RUN: begin
                if (!start) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end else if (!tx_en) begin
                    accept = 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == 3'(FLUSH_LEN - 1)) begin
                    state_d = start ? S_RUN : S_IDLE;
                    clr     = start;
                end else begin
                    flush_cnt_d = flush_cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clr) begin
            wr_ptr_d     = '0;
            sample_cnt_d = '0;
            zone_cnt_d   = '0;
            zone_addr_d  = '0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + CD_WD'(1);
            if (sample_cnt_q != CNT_WD'(DEPTH))
                sample_cnt_d = sample_cnt_q + CNT_WD'(1);
            // the last zone holds rather than wrapping back to zone 0
            if (zone_cnt_q == ZC_WD'(ZONE_LEN - 1)) begin
                zone_cnt_d = '0;
                if (zone_addr_q != '1)
                    zone_addr_d = zone_addr_q + ADDR_WD'(1);
            end else begin
                zone_cnt_d = zone_cnt_q + ZC_WD'(1);
            end
        end
    end

    always_comb begin : pipe
        lut_rd   = lut_mem[zone_addr_q];
        coarse_c = (lut_rd[LW-1:FRAC_WD] > CMAX) ? CMAX
                                                 : lut_rd[LW-1:FRAC_WD];

        s1_valid_d  = accept;
        s1_ptr_d    = wr_ptr_q;
        s1_cnt_d    = sample_cnt_q;
        s1_coarse_d = coarse_c;

        // taps before sample 0 of this acquisition are masked, not cleared
        rd0 = s1_ptr_q - s1_coarse_q;
        x0  = (s1_cnt_q >= {1'b0, s1_coarse_q}) ? buf_mem[rd0] : '0;

        s2_valid_d = s1_valid_q;
        s2_x0_d    = s1_valid_q ? x0 : s2_x0_q;

`ifdef DBF_FINE_INTERP_EN
        s1_frac_d = lut_rd[FRAC_WD-1:0];
        rd1       = rd0 - CD_WD'(1);
        x1        = (s1_cnt_q > {1'b0, s1_coarse_q}) ? buf_mem[rd1] : '0;
        s2_x1_d   = s1_valid_q ? x1 : s2_x1_q;
        s2_frac_d = s1_valid_q ? s1_frac_q : s2_frac_q;

        x0_e   = FIW'(s2_x0_q);
        x1_e   = FIW'(s2_x1_q);
        fr_e   = FIW'({1'b0, s2_frac_q});
        prod_f = (x1_e - x0_e) * fr_e;
        s3_y_d = YW'(x0_e + (prod_f >>> FRAC_WD));
`else
        s3_y_d = YW'(s2_x0_q);
`endif
        s3_valid_d = s2_valid_q;

        s4_valid_d = s3_valid_q;
        s4_p_d     = PW'(s3_y_q) * PW'($signed(apo_din));

        rnd_c = RW'(s4_p_q) + RND;
        shr_c = rnd_c >>> SHIFT;
        ext_c = SW'(shr_c);
        if (ext_c > OMAX)
            sat_c = OMAX;
        else if (ext_c < OMIN)
            sat_c = OMIN;
        else
            sat_c = ext_c;

        dout_valid_d = s4_valid_q;
        dout_d       = s4_valid_q ? OUT_WD'(sat_c) : '0;
    end

    always_ff @(posedge clk) begin
        if (accept)
            buf_mem[wr_ptr_q] <= ch_in;
    end

    always_ff @(posedge clk) begin
        if (lut_we)
            lut_mem[lut_waddr] <= lut_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            flush_cnt_q  <= '0;
            wr_ptr_q     <= '0;
            sample_cnt_q <= '0;
            zone_cnt_q   <= '0;
            zone_addr_q  <= '0;
            s1_valid_q   <= 1'b0;
            s1_ptr_q     <= '0;
            s1_cnt_q     <= '0;
            s1_coarse_q  <= '0;
            s2_valid_q   <= 1'b0;
            s2_x0_q      <= '0;
            s3_valid_q   <= 1'b0;
            s3_y_q       <= '0;
            s4_valid_q   <= 1'b0;
            s4_p_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            sample_cnt_q <= sample_cnt_d;
            zone_cnt_q   <= zone_cnt_d;
            zone_addr_q  <= zone_addr_d;
            s1_valid_q   <= s1_valid_d;
            s1_ptr_q     <= s1_ptr_d;
            s1_cnt_q     <= s1_cnt_d;
            s1_coarse_q  <= s1_coarse_d;
            s2_valid_q   <= s2_valid_d;
            s2_x0_q      <= s2_x0_d;
            s3_valid_q   <= s3_valid_d;
            s3_y_q       <= s3_y_d;
            s4_valid_q   <= s4_valid_d;
            s4_p_q       <= s4_p_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

`ifdef DBF_FINE_INTERP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_frac_q <= '0;
            s2_frac_q <= '0;
            s2_x1_q   <= '0;
        end else begin
            s1_frac_q <= s1_frac_d;
            s2_frac_q <= s2_frac_d;
            s2_x1_q   <= s2_x1_d;
        end
    end
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign cd_dout    = s2_x0_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dbf_ch_dynfocus.sv
// Bench for dbf_ch_dynfocus: sample-history model plus literal pins.
// Two instances share stimulus: default scaling and a 16-bit SHIFT=0 saturating one.
module tb_dbf_ch_dynfocus;
    localparam int ZL = 4;
    localparam longint SENT = -1000000000;
`ifdef DBF_FINE_INTERP_EN
    localparam bit FINE = 1'b1;
`else
    localparam bit FINE = 1'b0;
`endif

    typedef struct {
        int     cyc;
        int     idx;
        int     x0;
        longint e1;
        longint e2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, start, tx_en, lut_we;
    logic [13:0] ch_in;
    logic [15:0] apo_din;
    logic [7:0]  lut_waddr;
    logic [9:0]  lut_wdata;
    logic [31:0] dout;
    logic        dout_valid, busy;
    logic [13:0] cd_dout;
    logic [15:0] dout_s;
    logic        dout_valid_s, busy_s;
    logic [13:0] cd_dout_s;

    int     n_chk = 0;
    int     n_fail = 0;
    int     cyc_n = 0;
    int     n_valid = 0;
    int     hist[$];
    int     lut_c[256];
    int     lut_f[256];
    int     apo_m;
    exp_t   q[$];
    exp_t   cq[$];
    longint got1[2048];
    longint got2[2048];

    dbf_ch_dynfocus #(.ZONE_LEN(ZL)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_en(tx_en),
        .ch_in(ch_in), .apo_din(apo_din), .lut_we(lut_we),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .dout(dout), .dout_valid(dout_valid),
        .cd_dout(cd_dout), .busy(busy)
    );

    dbf_ch_dynfocus #(.ZONE_LEN(ZL), .OUT_WD(16), .SHIFT(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_en(tx_en),
        .ch_in(ch_in), .apo_din(apo_din), .lut_we(lut_we),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .dout(dout_s), .dout_valid(dout_valid_s),
        .cd_dout(cd_dout_s), .busy(busy_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input bit ok, input string nm,
                         input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) <<< (w - 1)) - 1;
        if (v > mx) return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lut_wr(input int a, input int c, input int f);
        lut_we    = 1'b1;
        lut_waddr = a[7:0];
        lut_wdata = {c[5:0], f[3:0]};
        lut_c[a]  = c;
        lut_f[a]  = f;
        tick();
        lut_we = 1'b0;
    endtask

    task automatic fill(input int c, input int f);
        for (int k = 0; k < 256; k++) lut_wr(k, c, f);
    endtask

    task automatic begin_acq(input int apo);
        apo_din = apo[15:0];
        apo_m   = apo;
        hist.delete();
        for (int i = 0; i < 2048; i++) begin
            got1[i] = SENT;
            got2[i] = SENT;
        end
        start = 1'b1;
        tx_en = 1'b0;
        tick();
        check(busy == 1'b1, "busy_run", busy, 1);
    endtask

    // expected output of one accepted sample from the acquisition history
    task automatic send(input int v);
        int k, z, c, f, x0, x1, yi, y;
        longint p;
        exp_t e;
        hist.push_back(v);
        k = hist.size() - 1;
        z = k / ZL;
        if (z > 255) z = 255;
        c = (lut_c[z] > 62) ? 62 : lut_c[z];
        f = lut_f[z];
        x0 = (k >= c) ? hist[k - c] : 0;
        x1 = (k >= c + 1) ? hist[k - c - 1] : 0;
        yi = x0 + (((x1 - x0) * f) >>> 4);
        y = FINE ? yi : x0;
        p = longint'(y) * apo_m;
        e.cyc = cyc_n;
        e.idx = k;
        e.x0  = x0;
        e.e1  = sat((p + 16384) >>> 15, 32);
        e.e2  = sat(p, 16);
        q.push_back(e);
        cq.push_back(e);
        ch_in = v[13:0];
        tx_en = 1'b0;
        tick();
    endtask

    task automatic bubble();
        tx_en = 1'b1;
        ch_in = 14'h1555;
        tick();
        tx_en = 1'b0;
    endtask

    task automatic end_acq();
        start = 1'b0;
        tx_en = 1'b0;
        repeat (8) tick();
        check(q.size() == 0, "drained", q.size(), 0);
        check(busy == 1'b0, "busy_idle", busy, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc + 5 < cyc_n) begin
                e = q.pop_front();
                check(1'b0, "lost_sample", e.idx, -1);
            end
            check(dout_valid_s == dout_valid, "valid_pair", dout_valid_s, dout_valid);
            if (dout_valid) begin
                n_valid++;
                if (q.size() == 0 || q[0].cyc + 5 != cyc_n) begin
                    check(1'b0, "valid_timing", cyc_n, (q.size() > 0) ? q[0].cyc + 5 : -1);
                end else begin
                    e = q.pop_front();
                    got1[e.idx] = longint'($signed(dout));
                    got2[e.idx] = longint'($signed(dout_s));
                    check(got1[e.idx] == e.e1, "dout", got1[e.idx], e.e1);
                    check(got2[e.idx] == e.e2, "dout_sat", got2[e.idx], e.e2);
                end
            end else begin
                check(dout == 0 && dout_s == 0, "dout_idle", dout, 0);
                if (q.size() > 0 && q[0].cyc + 5 == cyc_n) begin
                    e = q.pop_front();
                    check(1'b0, "missing_valid", 0, 1);
                end
            end
            if (cq.size() > 0 && cq[0].cyc + 2 == cyc_n) begin
                e = cq.pop_front();
                check(longint'($signed(cd_dout)) == e.x0, "cd_dout",
                      longint'($signed(cd_dout)), e.x0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        rst_n = 1'b0; start = 1'b0; tx_en = 1'b0; lut_we = 1'b0;
        ch_in = '0; apo_din = '0; lut_waddr = '0; lut_wdata = '0;
        #1;
        check(dout == 0, "rst_dout", dout, 0);
        check(dout_valid == 0, "rst_valid", dout_valid, 0);
        check(cd_dout == 0, "rst_cd", cd_dout, 0);
        check(busy == 0, "rst_busy", busy, 0);
        #21;
        rst_n = 1'b1;
        tick();

        // impulse through coarse delay 3
        fill(3, 0);
        begin_acq(16384);
        send(1000);
        repeat (7) send(0);
        end_acq();
        check(got1[3] == 500, "impulse", got1[3], 500);
        check(got1[2] == 0, "impulse_pre", got1[2], 0);
        check(got1[4] == 0, "impulse_post", got1[4], 0);

        // fine delay half-sample on a ramp
        fill(0, 8);
        begin_acq(32767);
        for (int n = 0; n < 10; n++) send(16 * n);
        end_acq();
        check(got1[4] == (FINE ? 56 : 64), "fine_ramp", got1[4], FINE ? 56 : 64);
        check(got1[0] == 0, "fine_ramp0", got1[0], 0);

        // coarse clamp and pointer wrap
        fill(63, 0);
        begin_acq(-32768);
        for (int n = 0; n < 200; n++) send(n + 1);
        end_acq();
        check(got1[61] == 0, "clamp_mask", got1[61], 0);
        check(got1[62] == -1, "clamp_first", got1[62], -1);
        check(got1[199] == -138, "clamp_wrap", got1[199], -138);

        // tx_en bubbles freeze the zone counter
        for (int k = 0; k < 256; k++) lut_wr(k, k % 61, 0);
        n0 = n_valid;
        begin_acq(-32768);
        for (int n = 0; n < 3; n++) send(n + 1);
        repeat (3) bubble();
        for (int n = 3; n < 12; n++) send(n + 1);
        end_acq();
        check(n_valid - n0 == 12, "tx_count", n_valid - n0, 12);
        check(got1[3] == -4, "tx_zone0", got1[3], -4);
        check(got1[4] == -4, "tx_zone1", got1[4], -4);
        check(got1[8] == -7, "tx_zone2", got1[8], -7);

        // zone stepping to saturation at the last zone
        begin_acq(-32768);
        for (int n = 0; n < 1100; n++) send(n);
        end_acq();
        check(got1[5] == -4, "zone1", got1[5], -4);
        check(got1[1017] == -1007, "zone254", got1[1017], -1007);
        check(got1[1050] == -1039, "zone255_hold", got1[1050], -1039);

        // saturation on the 16-bit instance
        begin_acq(-32768);
        repeat (6) send(-8192);
        end_acq();
        check(got2[0] == 32767, "sat_pos", got2[0], 32767);
        check(got1[0] == 8192, "sat_main", got1[0], 8192);
        check(got2[5] == 32767, "sat_pos5", got2[5], 32767);

        // asynchronous reset mid-acquisition
        begin_acq(16384);
        repeat (4) send(100);
        rst_n = 1'b0;
        #1;
        check(dout == 0, "midrst_dout", dout, 0);
        check(dout_valid == 0, "midrst_valid", dout_valid, 0);
        check(busy == 0, "midrst_busy", busy, 0);
        check(cd_dout == 0, "midrst_cd", cd_dout, 0);
        q.delete();
        cq.delete();
        start = 1'b0;
        #12;
        rst_n = 1'b1;
        repeat (6) tick();
        check(busy == 0, "post_rst_busy", busy, 0);
        check(dout_valid == 0, "post_rst_valid", dout_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
